// File: rtl/alu_result_demux4_if.sv
// Bundle of the result-demux handshake: one producer stream in, four
// independently stalled lanes plus their delivery counters out.
interface alu_result_demux4_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel1;
  logic             sel0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [CNT_W-1:0] lane_count0;
  logic [CNT_W-1:0] lane_count1;
  logic [CNT_W-1:0] lane_count2;
  logic [CNT_W-1:0] lane_count3;

  // Producer/consumer side: drives the result stream and per-lane ready.
  modport master (
    output in_valid, in_data, sel1, sel0, out_ready,
    input  in_ready, out_valid,
    input  out_data0, out_data1, out_data2, out_data3,
    input  lane_count0, lane_count1, lane_count2, lane_count3
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, sel1, sel0, out_ready,
    output in_ready, out_valid,
    output out_data0, out_data1, out_data2, out_data3,
    output lane_count0, lane_count1, lane_count2, lane_count3
  );
endinterface

// File: rtl/alu_result_demux4.sv
// Registered 1-to-4 ALU result demultiplexer: each lane holds one result
// behind its own valid/ready handshake and counts completed deliveries.
module alu_result_demux4 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_demux4_if.slave bus
);

  typedef enum logic [0:0] {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lane_state_e      state_r     [4];
  lane_state_e      state_nxt_s [4];
  logic [WIDTH-1:0] data_r      [4];
  logic [CNT_W-1:0] count_r     [4];

  logic [1:0] sel_s;
  logic [3:0] full_s;
  logic [3:0] drain_s;
  logic [3:0] accept_s;
  logic       in_ready_s;

  // Lane state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) state_r[i] <= LANE_EMPTY;
    end else begin
      for (int i = 0; i < 4; i++) state_r[i] <= state_nxt_s[i];
    end
  end

  // Lane next-state: a same-cycle accept wins over a drain (reload path).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        LANE_EMPTY: begin
          if (accept_s[i]) state_nxt_s[i] = LANE_FULL;
          else             state_nxt_s[i] = LANE_EMPTY;
        end
        LANE_FULL: begin
          if (accept_s[i])     state_nxt_s[i] = LANE_FULL;
          else if (drain_s[i]) state_nxt_s[i] = LANE_EMPTY;
          else                 state_nxt_s[i] = LANE_FULL;
        end
        default: state_nxt_s[i] = LANE_EMPTY;
      endcase
    end
  end

  // Lane outputs decoded from the state register.
  always_comb begin
    full_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (state_r[i] == LANE_FULL) full_s[i] = 1'b1;
      else                         full_s[i] = 1'b0;
    end
  end

  // Input steering; only the selected lane can see an accept.
  always_comb begin
    sel_s      = {bus.sel1, bus.sel0};
    in_ready_s = ~full_s[sel_s] | bus.out_ready[sel_s];
    drain_s    = full_s & bus.out_ready;
    accept_s   = 4'b0000;
    if (bus.in_valid && in_ready_s) accept_s[sel_s] = 1'b1;
    else                            accept_s = 4'b0000;
  end

  // Holding registers keep their last value after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) data_r[i] <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept_s[i]) data_r[i] <= bus.in_data;
        else             data_r[i] <= data_r[i];
      end
    end
  end

  // Saturating per-lane delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) count_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain_s[i] && (count_r[i] != CNT_MAX)) count_r[i] <= count_r[i] + CNT_ONE;
        else                                        count_r[i] <= count_r[i];
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = full_s;
  assign bus.out_data0   = data_r[0];
  assign bus.out_data1   = data_r[1];
  assign bus.out_data2   = data_r[2];
  assign bus.out_data3   = data_r[3];
  assign bus.lane_count0 = count_r[0];
  assign bus.lane_count1 = count_r[1];
  assign bus.lane_count2 = count_r[2];
  assign bus.lane_count3 = count_r[3];

endmodule

// File: tb/tb_alu_result_demux4.sv
// Scoreboard bench for alu_result_demux4: the driver queues each accepted
// result per lane, a negedge monitor pops and compares on every delivery.
module tb_alu_result_demux4;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_result_demux4_if #(.WIDTH(32), .CNT_W(8)) bus ();

  alu_result_demux4 #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q3[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int lane, input logic [31:0] d);
    case (lane)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic pop_exp(input int lane, output logic [31:0] d, output bit ok);
    ok = 1'b1;
    d  = 32'h0;
    case (lane)
      0: if (q0.size() > 0) d = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) d = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) d = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) d = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic logic [31:0] lane_data(input int lane);
    case (lane)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  // Monitor: every delivery (valid & ready) must match the oldest queued result.
  always @(negedge clk) begin
    logic [31:0] e;
    bit ok;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          pop_exp(i, e, ok);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL sb_unexpected lane%0d: got 0x%0h, nothing expected", i, lane_data(i));
          end else if (lane_data(i) !== e) begin
            errors++;
            $display("FAIL sb_data lane%0d: got 0x%0h expected 0x%0h", i, lane_data(i), e);
          end
        end
      end
    end
  end

  // Present one result, wait (bounded) for in_ready, queue it on accept.
  task automatic send(input logic [31:0] d, input logic [1:0] s, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.sel1     = s[1];
    bus.sel0     = s[0];
    waited       = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 expected 1 (lane %0d)", s);
    end else begin
      push_exp(int'(s), d);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] steer_data [4];
  int w;
  int wsum;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'h0;
    bus.sel1 = 1'b0;
    bus.sel0 = 1'b0;
    bus.out_ready = 4'b1111;
    #3;
    chk("reset_out_valid", {60'h0, bus.out_valid}, 64'h0);
    chk("reset_in_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("reset_count0", {56'h0, bus.lane_count0}, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Steering: four lanes back to back, each visible one cycle after accept.
    steer_data[0] = 32'hDEADBEEF;
    steer_data[1] = 32'h12345678;
    steer_data[2] = 32'hA5A5A5A5;
    steer_data[3] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      send(steer_data[i], i[1:0], w);
      chk("steer_wait", 64'(w), 64'h0);
      chk("steer_valid", {63'h0, bus.out_valid[i]}, 64'h1);
      chk("steer_latency", {32'h0, lane_data(i)}, {32'h0, steer_data[i]});
    end
    idle(2);
    chk("steer_count0", {56'h0, bus.lane_count0}, 64'd1);
    chk("steer_count1", {56'h0, bus.lane_count1}, 64'd1);
    chk("steer_count2", {56'h0, bus.lane_count2}, 64'd1);
    chk("steer_count3", {56'h0, bus.lane_count3}, 64'd1);
    chk("steer_drained", {60'h0, bus.out_valid}, 64'h0);

    // Backpressure on lane 2, then release with a same-cycle reload.
    bus.out_ready = 4'b1011;
    send(32'h11, 2'd2, w);
    chk("bp_first_data", {32'h0, bus.out_data2}, 64'h11);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h22;
    bus.sel1 = 1'b1;
    bus.sel0 = 1'b0;
    #1;
    chk("bp_in_ready_low", {63'h0, bus.in_ready}, 64'h0);
    idle(1);
    chk("bp_hold_data", {32'h0, bus.out_data2}, 64'h11);
    chk("bp_in_ready_low2", {63'h0, bus.in_ready}, 64'h0);
    chk("bp_count_stalled", {56'h0, bus.lane_count2}, 64'd1);
    bus.out_ready = 4'b1111;
    #1;
    chk("bp_in_ready_release", {63'h0, bus.in_ready}, 64'h1);
    push_exp(2, 32'h22);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_reload_data", {32'h0, bus.out_data2}, 64'h22);
    chk("bp_reload_valid", {63'h0, bus.out_valid[2]}, 64'h1);
    chk("bp_count_adv", {56'h0, bus.lane_count2}, 64'd2);
    idle(2);

    // Lane independence: lane 0 stalled, lane 1 still accepts at once.
    bus.out_ready = 4'b1110;
    send(32'h44, 2'd0, w);
    send(32'h33, 2'd1, w);
    chk("indep_wait", 64'(w), 64'h0);
    chk("indep_lane1", {32'h0, bus.out_data1}, 64'h33);
    chk("indep_lane0_data", {32'h0, bus.out_data0}, 64'h44);
    chk("indep_lane0_valid", {63'h0, bus.out_valid[0]}, 64'h1);
    bus.out_ready = 4'b1111;
    idle(2);
    chk("indep_count0", {56'h0, bus.lane_count0}, 64'd2);
    chk("indep_count1", {56'h0, bus.lane_count1}, 64'd2);

    // Streaming: ten results to lane 3 with no stall.
    wsum = 0;
    for (int i = 0; i < 10; i++) begin
      send(32'hC000_0000 + 32'(i), 2'd3, w);
      wsum += w;
      chk("stream_latency", {32'h0, bus.out_data3}, {32'h0, 32'hC000_0000 + 32'(i)});
    end
    chk("stream_no_stall", 64'(wsum), 64'h0);
    idle(2);
    chk("stream_count3", {56'h0, bus.lane_count3}, 64'd11);

    // Saturation: 300 deliveries on lane 0.
    for (int i = 0; i < 300; i++) send(32'(i), 2'd0, w);
    idle(2);
    chk("sat_count0", {56'h0, bus.lane_count0}, 64'd255);
    chk("sat_count1", {56'h0, bus.lane_count1}, 64'd2);
    chk("sat_count2", {56'h0, bus.lane_count2}, 64'd3);
    chk("sat_count3", {56'h0, bus.lane_count3}, 64'd11);
    chk("sb_drained", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'h0);

    // Asynchronous reset mid-cycle with lanes 1 and 3 full.
    bus.out_ready = 4'b0101;
    send(32'h55, 2'd1, w);
    send(32'h66, 2'd3, w);
    chk("rst_pre_valid", {60'h0, bus.out_valid}, 64'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {60'h0, bus.out_valid}, 64'h0);
    chk("rst_data1", {32'h0, bus.out_data1}, 64'h0);
    chk("rst_data3", {32'h0, bus.out_data3}, 64'h0);
    chk("rst_data0", {32'h0, bus.out_data0}, 64'h0);
    chk("rst_count0", {56'h0, bus.lane_count0}, 64'h0);
    chk("rst_count3", {56'h0, bus.lane_count3}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      bus.sel1 = i[1];
      bus.sel0 = i[0];
      #0.1;
      chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    end
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
